// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall, bubble and flush control.
// Carries writeback, HI/LO, memory-access and exception fields into MEM,
// holds the MADD/MSUB temporaries across stalls, and counts inserted bubbles.
module ex_mem_pipe_reg #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned ALUOP_W = 8,
   parameter int unsigned EXC_W   = 32,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned PERF_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_ex,
   input  logic                  stall_mem,
   input  logic                  flush,
   input  logic [RADDR_W-1:0]    ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic                  ex_whilo,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [EXC_W-1:0]      ex_excepttype,
   input  logic [DATA_W-1:0]     ex_pc,
   input  logic                  ex_in_delay,
   input  logic [2*DATA_W-1:0]   hilo_i,
   input  logic [CNT_W-1:0]      cnt_i,
   output logic [RADDR_W-1:0]    mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic                  mem_whilo,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic [EXC_W-1:0]      mem_excepttype,
   output logic [DATA_W-1:0]     mem_pc,
   output logic                  mem_in_delay,
   output logic                  mem_valid,
   output logic [2*DATA_W-1:0]   hilo_o,
   output logic [CNT_W-1:0]      cnt_o,
   output logic [PERF_W-1:0]     bubble_cnt
);

   localparam int unsigned HILO_W = 2 * DATA_W;

   // Instruction payload travelling from EX to MEM.
   typedef struct packed {
      logic [RADDR_W-1:0] wd;
      logic               wreg;
      logic [DATA_W-1:0]  wdata;
      logic [DATA_W-1:0]  hi;
      logic [DATA_W-1:0]  lo;
      logic               whilo;
      logic [ALUOP_W-1:0] aluop;
      logic [DATA_W-1:0]  mem_addr;
      logic [DATA_W-1:0]  reg2;
      logic [EXC_W-1:0]   excepttype;
      logic [DATA_W-1:0]  pc;
      logic               in_delay;
   } payload_t;

   payload_t            ex_pay;
   payload_t            pay_q;
   logic                valid_q;
   logic [HILO_W-1:0]   hilo_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [PERF_W-1:0]   bub_q;

   // stall_mem alone (stall_ex=0) never comes from the stall controller; it
   // is folded into hold so MEM never loses an instruction it is still using.
   logic hold;
   logic bubble;

   assign hold   = stall_mem;
   assign bubble = stall_ex & ~stall_mem;

   // Gather the EX-side fields into one payload.
   always_comb begin
      ex_pay            = '0;
      ex_pay.wd         = ex_wd;
      ex_pay.wreg       = ex_wreg;
      ex_pay.wdata      = ex_wdata;
      ex_pay.hi         = ex_hi;
      ex_pay.lo         = ex_lo;
      ex_pay.whilo      = ex_whilo;
      ex_pay.aluop      = ex_aluop;
      ex_pay.mem_addr   = ex_mem_addr;
      ex_pay.reg2       = ex_reg2;
      ex_pay.excepttype = ex_excepttype;
      ex_pay.pc         = ex_pc;
      ex_pay.in_delay   = ex_in_delay;
   end

   // Payload and valid: cleared on reset, flush or bubble; loaded on advance.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pay_q   <= '0;
         valid_q <= 1'b0;
      end else if (hold) begin
         pay_q   <= pay_q;
         valid_q <= valid_q;
      end else if (bubble) begin
         pay_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         pay_q   <= ex_pay;
         valid_q <= 1'b1;
      end
   end

   // Multi-cycle MADD/MSUB temporaries: captured while EX is stalled so the
   // op can resume, discarded once the instruction advances.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hilo_q <= '0;
         cnt_q  <= '0;
      end else if (hold) begin
         hilo_q <= hilo_q;
         cnt_q  <= cnt_q;
      end else if (bubble) begin
         hilo_q <= hilo_i;
         cnt_q  <= cnt_i;
      end else begin
         hilo_q <= '0;
         cnt_q  <= '0;
      end
   end

   // Saturating bubble counter; only reset clears it, flush leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         bub_q <= '0;
      end else if (!flush && bubble && (bub_q != {PERF_W{1'b1}})) begin
         bub_q <= bub_q + PERF_W'(1);
      end
   end

   assign mem_wd         = pay_q.wd;
   assign mem_wreg       = pay_q.wreg;
   assign mem_wdata      = pay_q.wdata;
   assign mem_hi         = pay_q.hi;
   assign mem_lo         = pay_q.lo;
   assign mem_whilo      = pay_q.whilo;
   assign mem_aluop      = pay_q.aluop;
   assign mem_mem_addr   = pay_q.mem_addr;
   assign mem_reg2       = pay_q.reg2;
   assign mem_excepttype = pay_q.excepttype;
   assign mem_pc         = pay_q.pc;
   assign mem_in_delay   = pay_q.in_delay;
   assign mem_valid      = valid_q;
   assign hilo_o         = hilo_q;
   assign cnt_o          = cnt_q;
   assign bubble_cnt     = bub_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed scenarios plus random
// traffic against a behavioural model of the stage register.
module tb_ex_mem_pipe_reg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned ALUOP_W = 8;
   localparam int unsigned EXC_W   = 32;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned PERF_W  = 16;
   localparam int unsigned PERF_P  = 2;
   localparam int unsigned PAY_W   = RADDR_W + 1 + 4*DATA_W + 1 + ALUOP_W + 2*DATA_W + EXC_W + 1;

   logic clk = 1'b0;
   logic rst, stall_ex, stall_mem, flush;
   logic [RADDR_W-1:0]  ex_wd;
   logic                ex_wreg;
   logic [DATA_W-1:0]   ex_wdata, ex_hi, ex_lo;
   logic                ex_whilo;
   logic [ALUOP_W-1:0]  ex_aluop;
   logic [DATA_W-1:0]   ex_mem_addr, ex_reg2;
   logic [EXC_W-1:0]    ex_excepttype;
   logic [DATA_W-1:0]   ex_pc;
   logic                ex_in_delay;
   logic [2*DATA_W-1:0] hilo_i;
   logic [CNT_W-1:0]    cnt_i;

   logic [RADDR_W-1:0]  mem_wd;
   logic                mem_wreg;
   logic [DATA_W-1:0]   mem_wdata, mem_hi, mem_lo;
   logic                mem_whilo;
   logic [ALUOP_W-1:0]  mem_aluop;
   logic [DATA_W-1:0]   mem_mem_addr, mem_reg2;
   logic [EXC_W-1:0]    mem_excepttype;
   logic [DATA_W-1:0]   mem_pc;
   logic                mem_in_delay, mem_valid;
   logic [2*DATA_W-1:0] hilo_o;
   logic [CNT_W-1:0]    cnt_o;
   logic [PERF_W-1:0]   bubble_cnt;

   logic [RADDR_W-1:0]  p_wd;
   logic                p_wreg;
   logic [DATA_W-1:0]   p_wdata, p_hi, p_lo;
   logic                p_whilo;
   logic [ALUOP_W-1:0]  p_aluop;
   logic [DATA_W-1:0]   p_mem_addr, p_reg2;
   logic [EXC_W-1:0]    p_excepttype;
   logic [DATA_W-1:0]   p_pc;
   logic                p_in_delay, p_valid;
   logic [2*DATA_W-1:0] p_hilo;
   logic [CNT_W-1:0]    p_cnt;
   logic [PERF_P-1:0]   p_bubble_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [PAY_W-1:0]    exp_pay;
   logic                exp_valid;
   logic [2*DATA_W-1:0] exp_hilo;
   logic [CNT_W-1:0]    exp_cnt;
   int                  exp_bub;
   int                  exp_bub_p;

   always #5 clk = ~clk;

   ex_mem_pipe_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ALUOP_W(ALUOP_W),
                     .EXC_W(EXC_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .ex_excepttype(ex_excepttype), .ex_pc(ex_pc), .ex_in_delay(ex_in_delay),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
      .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
      .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_excepttype(mem_excepttype),
      .mem_pc(mem_pc), .mem_in_delay(mem_in_delay), .mem_valid(mem_valid),
      .hilo_o(hilo_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt));

   ex_mem_pipe_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ALUOP_W(ALUOP_W),
                     .EXC_W(EXC_W), .CNT_W(CNT_W), .PERF_W(PERF_P)) dut_p (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
      .ex_excepttype(ex_excepttype), .ex_pc(ex_pc), .ex_in_delay(ex_in_delay),
      .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(p_wd), .mem_wreg(p_wreg), .mem_wdata(p_wdata), .mem_hi(p_hi),
      .mem_lo(p_lo), .mem_whilo(p_whilo), .mem_aluop(p_aluop),
      .mem_mem_addr(p_mem_addr), .mem_reg2(p_reg2), .mem_excepttype(p_excepttype),
      .mem_pc(p_pc), .mem_in_delay(p_in_delay), .mem_valid(p_valid),
      .hilo_o(p_hilo), .cnt_o(p_cnt), .bubble_cnt(p_bubble_cnt));

   function automatic logic [PAY_W-1:0] in_pay();
      return {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
              ex_mem_addr, ex_reg2, ex_excepttype, ex_pc, ex_in_delay};
   endfunction

   function automatic logic [PAY_W-1:0] dut_pay();
      return {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
              mem_mem_addr, mem_reg2, mem_excepttype, mem_pc, mem_in_delay};
   endfunction

   function automatic logic [PAY_W-1:0] dutp_pay();
      return {p_wd, p_wreg, p_wdata, p_hi, p_lo, p_whilo, p_aluop,
              p_mem_addr, p_reg2, p_excepttype, p_pc, p_in_delay};
   endfunction

   task automatic rand_fields();
      ex_wd         = RADDR_W'($urandom);
      ex_wreg       = 1'($urandom);
      ex_wdata      = $urandom;
      ex_hi         = $urandom;
      ex_lo         = $urandom;
      ex_whilo      = 1'($urandom);
      ex_aluop      = ALUOP_W'($urandom);
      ex_mem_addr   = $urandom;
      ex_reg2       = $urandom;
      ex_excepttype = $urandom;
      ex_pc         = $urandom;
      ex_in_delay   = 1'($urandom);
      hilo_i        = {$urandom, $urandom};
      cnt_i         = CNT_W'($urandom);
   endtask

   // Model: the spec's priority list applied to the values present at the edge.
   task automatic model_edge();
      int max_bub, max_bub_p;
      max_bub   = (1 << PERF_W) - 1;
      max_bub_p = (1 << PERF_P) - 1;
      if (rst) begin
         exp_pay = '0; exp_valid = 1'b0; exp_hilo = '0; exp_cnt = '0;
         exp_bub = 0;  exp_bub_p = 0;
      end else if (flush) begin
         exp_pay = '0; exp_valid = 1'b0; exp_hilo = '0; exp_cnt = '0;
      end else if (stall_mem) begin
         // hold, including the unused stall_ex=0/stall_mem=1 combination
      end else if (stall_ex) begin
         exp_pay = '0; exp_valid = 1'b0; exp_hilo = hilo_i; exp_cnt = cnt_i;
         exp_bub   = (exp_bub   + 1 > max_bub)   ? max_bub   : exp_bub + 1;
         exp_bub_p = (exp_bub_p + 1 > max_bub_p) ? max_bub_p : exp_bub_p + 1;
      end else begin
         exp_pay = in_pay(); exp_valid = 1'b1; exp_hilo = '0; exp_cnt = '0;
      end
   endtask

   // Advance one clock: update the model, then sample 1 time unit after the edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctl(input logic r, input logic f, input logic sx, input logic sm);
      rst = r; flush = f; stall_ex = sx; stall_mem = sm;
   endtask

   task automatic test_reset();
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_hi = '1; ex_lo = '1; ex_whilo = 1'b1;
      ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1; ex_excepttype = '1; ex_pc = '1;
      ex_in_delay = 1'b1; hilo_i = '1; cnt_i = '1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (dut_pay() !== '0 || mem_valid !== 1'b0) begin
            $display("FAIL reset_pay cyc%0d got=%h valid=%b exp=0", i, dut_pay(), mem_valid); errors++;
         end
         checks++;
         if (hilo_o !== '0 || cnt_o !== '0 || bubble_cnt !== '0 || p_bubble_cnt !== '0) begin
            $display("FAIL reset_aux cyc%0d hilo=%h cnt=%0d bub=%0d bubp=%0d exp=0", i, hilo_o, cnt_o, bubble_cnt, p_bubble_cnt);
            errors++;
         end
      end
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_advance();
      rand_fields();
      ex_wd = 5'd3; ex_wdata = 32'hDEADBEEF; ex_wreg = 1'b1;
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (mem_wd !== 5'd3 || mem_wdata !== 32'hDEADBEEF || mem_wreg !== 1'b1 ||
          mem_valid !== 1'b1 || cnt_o !== '0 || hilo_o !== '0) begin
         $display("FAIL advance wd=%0d wdata=%h wreg=%b valid=%b cnt=%0d exp wd=3 wdata=deadbeef wreg=1 valid=1 cnt=0",
                  mem_wd, mem_wdata, mem_wreg, mem_valid, cnt_o);
         errors++;
      end
      checks++;
      if (dut_pay() !== exp_pay) begin
         $display("FAIL advance_fields got=%h exp=%h", dut_pay(), exp_pay); errors++;
      end
   endtask

   task automatic test_hold();
      int bub0;
      bub0 = exp_bub;
      set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         rand_fields();
         step();
         checks++;
         if (mem_wd !== 5'd3 || mem_wdata !== 32'hDEADBEEF || mem_valid !== 1'b1 ||
             dut_pay() !== exp_pay || int'(bubble_cnt) !== bub0) begin
            $display("FAIL hold cyc%0d wd=%0d wdata=%h valid=%b bub=%0d exp wd=3 wdata=deadbeef valid=1 bub=%0d",
                     i, mem_wd, mem_wdata, mem_valid, bubble_cnt, bub0);
            errors++;
         end
      end
      // stall_mem without stall_ex also holds
      rand_fields();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if (mem_wdata !== 32'hDEADBEEF || mem_valid !== 1'b1 || int'(bubble_cnt) !== bub0) begin
         $display("FAIL hold_illegal wdata=%h valid=%b bub=%0d exp wdata=deadbeef valid=1 bub=%0d",
                  mem_wdata, mem_valid, bubble_cnt, bub0);
         errors++;
      end
   endtask

   task automatic test_bubble();
      int bub0;
      bub0 = int'(bubble_cnt);
      rand_fields();
      hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
      set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checks++;
      if (mem_valid !== 1'b0 || mem_wreg !== 1'b0 || dut_pay() !== '0 ||
          hilo_o !== 64'h1_0000_0002 || cnt_o !== 2'd1 || int'(bubble_cnt) !== bub0 + 1) begin
         $display("FAIL bubble valid=%b wreg=%b hilo=%h cnt=%0d bub=%0d exp valid=0 wreg=0 hilo=100000002 cnt=1 bub=%0d",
                  mem_valid, mem_wreg, hilo_o, cnt_o, bubble_cnt, bub0 + 1);
         errors++;
      end
   endtask

   task automatic test_flush();
      int bub0;
      // load a real instruction first so the clear is visible
      rand_fields();
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rand_fields();
      hilo_i = 64'hAAAA_5555_1234_8765; cnt_i = 2'd2;
      set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
      step();
      bub0 = int'(bubble_cnt);
      rand_fields();
      ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
      set_ctl(1'b0, 1'b1, 1'b1, 1'b0);
      step();
      checks++;
      if (dut_pay() !== '0 || mem_valid !== 1'b0 || hilo_o !== '0 || cnt_o !== '0 ||
          int'(bubble_cnt) !== bub0 || int'(bubble_cnt) !== exp_bub) begin
         $display("FAIL flush pay=%h valid=%b hilo=%h cnt=%0d bub=%0d exp pay=0 valid=0 hilo=0 cnt=0 bub=%0d",
                  dut_pay(), mem_valid, hilo_o, cnt_o, bubble_cnt, bub0);
         errors++;
      end
   endtask

   task automatic test_saturate();
      logic [PERF_P-1:0] seq [5];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3; seq[4] = 2'd3;
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rand_fields();
         step();
         checks++;
         if (p_bubble_cnt !== seq[i] || int'(p_bubble_cnt) !== exp_bub_p) begin
            $display("FAIL saturate cyc%0d got=%0d exp=%0d", i, p_bubble_cnt, seq[i]); errors++;
         end
      end
      checks++;
      if (int'(bubble_cnt) !== 5) begin
         $display("FAIL saturate_wide got=%0d exp=5", bubble_cnt); errors++;
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         rand_fields();
         set_ctl(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), 1'($urandom));
         step();
         checks++;
         if (dut_pay() !== exp_pay || mem_valid !== exp_valid || hilo_o !== exp_hilo ||
             cnt_o !== exp_cnt || int'(bubble_cnt) !== exp_bub) begin
            if (bad < 10)
               $display("FAIL random cyc%0d pay=%h v=%b hilo=%h cnt=%0d bub=%0d exp pay=%h v=%b hilo=%h cnt=%0d bub=%0d",
                        i, dut_pay(), mem_valid, hilo_o, cnt_o, bubble_cnt,
                        exp_pay, exp_valid, exp_hilo, exp_cnt, exp_bub);
            bad++; errors++;
         end
         checks++;
         if (dutp_pay() !== exp_pay || p_valid !== exp_valid || p_hilo !== exp_hilo ||
             p_cnt !== exp_cnt || int'(p_bubble_cnt) !== exp_bub_p) begin
            if (bad < 10)
               $display("FAIL random_p cyc%0d v=%b bub=%0d exp v=%b bub=%0d",
                        i, p_valid, p_bubble_cnt, exp_valid, exp_bub_p);
            bad++; errors++;
         end
      end
   endtask

   initial begin
      set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      rand_fields();
      exp_pay = '0; exp_valid = 1'b0; exp_hilo = '0; exp_cnt = '0;
      exp_bub = 0; exp_bub_p = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_advance();
      test_hold();
      test_bubble();
      test_flush();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
